demux_buf: RTL and testbench

Buffered 1:2 demultiplexer that routes `WIDTH`-bit words from a single producer to one of two consumer lanes, selected per word by `sel`. Each lane has a small FIFO with valid/pop handshake, so the two consumers can drain at independent rates. It sits on the distribution side of the 2:1 selection path: the words that a 2:1 mux merges are split back into two streams here.

---
 rtl/demux_buf.sv | 82 ++++++++
 tb/tb_demux_buf.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_buf.sv
// demux_buf: buffered 1:2 demultiplexer routing words into two independent lane FIFOs.
// Optional feature: define DEMUX_ERR_EN to add a sticky err output for pushes refused by a full lane.
module demux_buf #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             sel,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_out_0,
    output logic [WIDTH-1:0] data_out_1,
    output logic             valid_out_0,
    output logic             valid_out_1,
    input  logic             pop_0,
    input  logic             pop_1,
    output logic             full_0,
    output logic             full_1
`ifdef DEMUX_ERR_EN
    ,
    output logic             err
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [2][DEPTH];
    logic [AW-1:0]    r_wp  [2];
    logic [AW-1:0]    r_rp  [2];
    logic [AW:0]      r_cnt [2];
    logic [1:0]       w_full;
    logic [1:0]       w_valid;
    logic [1:0]       w_pop_req;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;

    assign w_pop_req   = {pop_1, pop_0};
    assign ready_in    = !w_full[sel];
    assign data_out_0  = r_mem[0][r_rp[0]];
    assign data_out_1  = r_mem[1][r_rp[1]];
    assign valid_out_0 = w_valid[0];
    assign valid_out_1 = w_valid[1];
    assign full_0      = w_full[0];
    assign full_1      = w_full[1];

    for (genvar n = 0; n < 2; n++) begin : g_lane
        assign w_full[n]  = r_cnt[n] == (AW+1)'(DEPTH);
        assign w_valid[n] = r_cnt[n] != '0;
        assign w_push[n]  = valid_in && ready_in && (sel == 1'(n));
        assign w_pop[n]   = w_pop_req[n] && w_valid[n];

        // Storage write: data only lands when the push is accepted outside reset.
        always_ff @(posedge clk) begin
            if (reset && w_push[n]) r_mem[n][r_wp[n]] <= data_in;
        end

        // Pointers wrap naturally at DEPTH (power of two); count tracks push minus pop.
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_wp[n]  <= '0;
                r_rp[n]  <= '0;
                r_cnt[n] <= '0;
            end else begin
                if (w_push[n]) r_wp[n] <= r_wp[n] + 1'b1;
                if (w_pop[n]) r_rp[n] <= r_rp[n] + 1'b1;
                r_cnt[n] <= r_cnt[n] + (AW+1)'(w_push[n]) - (AW+1)'(w_pop[n]);
            end
        end
    end

`ifdef DEMUX_ERR_EN
    logic r_err;
    assign err = r_err;

    // Sticky flag for a word offered while its lane was full; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) r_err <= 1'b0;
        else if (valid_in && !ready_in) r_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_demux_buf.sv
// tb_demux_buf: directed vector table plus randomized traffic checked against a queue model.
module tb_demux_buf;
    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid_in;
    logic             sel;
    logic [WIDTH-1:0] data_in;
    logic             ready_in;
    logic [WIDTH-1:0] data_out_0;
    logic [WIDTH-1:0] data_out_1;
    logic             valid_out_0;
    logic             valid_out_1;
    logic             pop_0;
    logic             pop_1;
    logic             full_0;
    logic             full_1;
`ifdef DEMUX_ERR_EN
    logic             err;
`endif

    demux_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .valid_in(valid_in),
        .sel(sel),
        .data_in(data_in),
        .ready_in(ready_in),
        .data_out_0(data_out_0),
        .data_out_1(data_out_1),
        .valid_out_0(valid_out_0),
        .valid_out_1(valid_out_1),
        .pop_0(pop_0),
        .pop_1(pop_1),
        .full_0(full_0),
        .full_1(full_1)
`ifdef DEMUX_ERR_EN
        ,
        .err(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       vin;
        logic       s;
        logic [3:0] din;
        logic       p0;
        logic       p1;
        logic       v0;
        logic       v1;
        logic       f0;
        logic       f1;
        logic       rdy;
        logic [3:0] d0;
        logic [3:0] d1;
        logic       e;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic       m_err;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: per-lane queues updated from pre-edge occupancy.
    task automatic model_edge();
        int  n0 = q0.size();
        int  n1 = q1.size();
        bit  rdy = sel ? (n1 < DEPTH) : (n0 < DEPTH);
        if (!reset) begin
            q0.delete();
            q1.delete();
            m_err = 1'b0;
            return;
        end
        if (pop_0 && n0 > 0) void'(q0.pop_front());
        if (pop_1 && n1 > 0) void'(q1.pop_front());
        if (valid_in && rdy) begin
            if (sel) q1.push_back(data_in);
            else q0.push_back(data_in);
        end
        if (valid_in && !rdy) m_err = 1'b1;
    endtask

    task automatic step(input logic r, input logic v, input logic s, input logic [3:0] d,
                        input logic p0, input logic p1);
        reset = r;
        valid_in = v;
        sel = s;
        data_in = d;
        pop_0 = p0;
        pop_1 = p1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model();
        chk("valid_out_0", 32'(valid_out_0), 32'(q0.size() != 0));
        chk("valid_out_1", 32'(valid_out_1), 32'(q1.size() != 0));
        chk("full_0", 32'(full_0), 32'(q0.size() == DEPTH));
        chk("full_1", 32'(full_1), 32'(q1.size() == DEPTH));
        chk("ready_in", 32'(ready_in), 32'(sel ? q1.size() < DEPTH : q0.size() < DEPTH));
        if (q0.size() > 0) chk("data_out_0", 32'(data_out_0), 32'(q0[0]));
        if (q1.size() > 0) chk("data_out_1", 32'(data_out_1), 32'(q1[0]));
`ifdef DEMUX_ERR_EN
        chk("err", 32'(err), 32'(m_err));
`endif
    endtask

    task automatic add(input logic r, input logic v, input logic s, input logic [3:0] d,
                       input logic p0, input logic p1, input logic v0, input logic v1,
                       input logic f0, input logic f1, input logic rdy, input logic [3:0] d0,
                       input logic [3:0] d1, input logic e);
        vecs.push_back('{r, v, s, d, p0, p1, v0, v1, f0, f1, rdy, d0, d1, e});
    endtask

    initial begin
        m_err = 1'b0;
        //  rst v  s  din   p0 p1 | v0 v1 f0 f1 rdy d0    d1    err
        add(0, 1, 0, 4'hF, 1, 1,   0, 0, 0, 0, 1,  4'h0, 4'h0, 0);
        add(0, 0, 0, 4'h0, 0, 0,   0, 0, 0, 0, 1,  4'h0, 4'h0, 0);
        add(1, 0, 0, 4'h0, 0, 0,   0, 0, 0, 0, 1,  4'h0, 4'h0, 0);
        add(1, 1, 0, 4'hA, 0, 0,   1, 0, 0, 0, 1,  4'hA, 4'h0, 0);
        add(1, 1, 1, 4'h5, 0, 0,   1, 1, 0, 0, 1,  4'hA, 4'h5, 0);
        add(1, 0, 0, 4'h0, 1, 1,   0, 0, 0, 0, 1,  4'h0, 4'h0, 0);
        add(1, 1, 0, 4'h1, 0, 0,   1, 0, 0, 0, 1,  4'h1, 4'h0, 0);
        add(1, 1, 0, 4'h2, 0, 0,   1, 0, 1, 0, 0,  4'h1, 4'h0, 0);
        add(1, 1, 0, 4'h3, 0, 0,   1, 0, 1, 0, 0,  4'h1, 4'h0, 1);
        add(1, 1, 1, 4'h3, 0, 0,   1, 1, 1, 0, 1,  4'h1, 4'h3, 1);
        add(1, 0, 0, 4'h0, 1, 1,   1, 0, 0, 0, 1,  4'h2, 4'h0, 1);
        add(1, 0, 0, 4'h0, 1, 0,   0, 0, 0, 0, 1,  4'h0, 4'h0, 1);
        add(1, 1, 0, 4'h7, 0, 0,   1, 0, 0, 0, 1,  4'h7, 4'h0, 1);
        add(1, 1, 0, 4'h8, 1, 0,   1, 0, 0, 0, 1,  4'h8, 4'h0, 1);
        add(1, 0, 0, 4'h0, 1, 0,   0, 0, 0, 0, 1,  4'h0, 4'h0, 1);
        add(1, 1, 0, 4'h1, 0, 0,   1, 0, 0, 0, 1,  4'h1, 4'h0, 1);
        add(1, 1, 0, 4'h2, 0, 0,   1, 0, 1, 0, 0,  4'h1, 4'h0, 1);
        add(1, 0, 0, 4'h0, 1, 0,   1, 0, 0, 0, 1,  4'h2, 4'h0, 1);
        add(1, 0, 0, 4'h0, 1, 0,   0, 0, 0, 0, 1,  4'h0, 4'h0, 1);
        add(1, 0, 0, 4'h0, 1, 0,   0, 0, 0, 0, 1,  4'h0, 4'h0, 1);
        add(1, 1, 0, 4'h9, 0, 0,   1, 0, 0, 0, 1,  4'h9, 4'h0, 1);
        add(1, 1, 0, 4'hB, 1, 0,   1, 0, 0, 0, 1,  4'hB, 4'h0, 1);
        add(1, 1, 0, 4'hC, 1, 0,   1, 0, 0, 0, 1,  4'hC, 4'h0, 1);
        add(1, 0, 0, 4'h0, 1, 0,   0, 0, 0, 0, 1,  4'h0, 4'h0, 1);
        add(1, 1, 1, 4'h4, 0, 0,   0, 1, 0, 0, 1,  4'h0, 4'h4, 1);
        add(1, 1, 1, 4'h6, 0, 0,   0, 1, 0, 1, 0,  4'h0, 4'h4, 1);
        add(0, 1, 1, 4'hE, 0, 0,   0, 0, 0, 0, 1,  4'h0, 4'h0, 0);
        add(1, 0, 1, 4'h0, 0, 0,   0, 0, 0, 0, 1,  4'h0, 4'h0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].vin, vecs[i].s, vecs[i].din, vecs[i].p0, vecs[i].p1);
            chk($sformatf("v%0d valid_out_0", i), 32'(valid_out_0), 32'(vecs[i].v0));
            chk($sformatf("v%0d valid_out_1", i), 32'(valid_out_1), 32'(vecs[i].v1));
            chk($sformatf("v%0d full_0", i), 32'(full_0), 32'(vecs[i].f0));
            chk($sformatf("v%0d full_1", i), 32'(full_1), 32'(vecs[i].f1));
            chk($sformatf("v%0d ready_in", i), 32'(ready_in), 32'(vecs[i].rdy));
            if (vecs[i].v0) chk($sformatf("v%0d data_out_0", i), 32'(data_out_0), 32'(vecs[i].d0));
            if (vecs[i].v1) chk($sformatf("v%0d data_out_1", i), 32'(data_out_1), 32'(vecs[i].d1));
`ifdef DEMUX_ERR_EN
            chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].e));
`endif
        end

        begin
            logic       hold = 1'b0;
            logic       r;
            logic       v;
            logic       s = 1'b0;
            logic [3:0] d = '0;
            step(0, 0, 0, 4'h0, 0, 0);
            check_model();
            for (int k = 0; k < 600; k++) begin
                bit acc;
                r = ($urandom_range(0, 59) != 0);
                v = hold ? 1'b1 : ($urandom_range(0, 9) < 7);
                if (!hold) begin
                    s = 1'($urandom);
                    d = 4'($urandom);
                end
                acc = r && v && (s ? q1.size() < DEPTH : q0.size() < DEPTH);
                hold = r && v && !acc;
                step(r, v, s, d, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4);
                check_model();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
